// File: rtl/byte_mem_responder.sv
// byte_mem_responder: byte-serial memory responder with RAM, TX FIFO, RX port, status/halt IO and optional LFSR stalls
module byte_mem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter logic [31:0] IO_BASE = 32'h0003_0000,
  parameter int TX_DEPTH_LOG = 3,
  parameter bit STALL_EN = 1'b0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic [31:0] mem_a,
  input  logic mem_wr,
  input  logic [7:0] mem_dout,
  output logic [7:0] mem_din,
  output logic mem_valid,
  output logic [7:0] tx_data,
  output logic tx_valid,
  input  logic tx_ready,
  input  logic [7:0] rx_data,
  input  logic rx_valid,
  output logic rx_ready,
  output logic halt_out
);
  localparam logic [TX_DEPTH_LOG:0] TX_FULL = {1'b1, {TX_DEPTH_LOG{1'b0}}};
  localparam logic [TX_DEPTH_LOG:0] CNT_ONE = (TX_DEPTH_LOG + 1)'(1);
  localparam logic [TX_DEPTH_LOG-1:0] PTR_ONE = TX_DEPTH_LOG'(1);
  logic [7:0] ram [2**ADDR_WIDTH];
  logic [7:0] fifo [2**TX_DEPTH_LOG];
  logic [TX_DEPTH_LOG-1:0] wr_ptr, rd_ptr;
  logic [TX_DEPTH_LOG:0] tx_cnt;
  logic [15:0] lfsr;
  logic is_io, io_tx, io_st, tx_full, stall, block, push, pop;
  logic [7:0] rd_data;
  always_comb begin
    is_io = mem_a >= IO_BASE;
    io_tx = mem_a == IO_BASE;
    io_st = mem_a == IO_BASE + 32'd4;
    tx_full = tx_cnt == TX_FULL;
    stall = STALL_EN && lfsr[1:0] == 2'b00;
    block = io_tx && (mem_wr ? tx_full : !rx_valid);
    mem_valid = rst_n_in && !halt_out && !stall && !block;
    rx_ready = mem_valid && io_tx && !mem_wr;
    push = mem_valid && io_tx && mem_wr;
    tx_valid = tx_cnt != '0;
    tx_data = fifo[rd_ptr];
    pop = tx_valid && tx_ready;
    rd_data = !is_io ? ram[mem_a[ADDR_WIDTH-1:0]] : io_tx ? rx_data : io_st ? {6'b0, rx_valid, tx_full} : 8'h00;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      lfsr <= LFSR_SEED;
      mem_din <= '0;
      halt_out <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      tx_cnt <= '0;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (mem_valid && !mem_wr) mem_din <= rd_data;
      if (mem_valid && mem_wr && io_st) halt_out <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push != pop) tx_cnt <= push ? tx_cnt + CNT_ONE : tx_cnt - CNT_ONE;
    end
  // storage arrays carry no reset so RAM contents survive rst_n_in
  always_ff @(posedge clk_in) begin
    if (mem_valid && mem_wr && !is_io) ram[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
    if (push) fifo[wr_ptr] <= mem_dout;
  end
endmodule

// File: tb/tb_byte_mem_responder.sv
// tb_byte_mem_responder: vector table, directed corner sequences and random traffic against a behavioural model
module tb_byte_mem_responder;
  localparam logic [31:0] IO = 32'h0003_0000;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  logic rst_n_in;
  logic [31:0] mem_a, s_a;
  logic mem_wr, s_wr, mem_valid, s_valid, tx_valid, s_txv, tx_ready, rx_valid, rx_ready, s_rxr, halt_out, s_halt;
  logic [7:0] mem_dout, s_dout, mem_din, s_din, tx_data, s_txd, rx_data;
  byte_mem_responder dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_valid(mem_valid), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .halt_out(halt_out)
  );
  byte_mem_responder #(.STALL_EN(1'b1), .LFSR_SEED(SEED)) sdut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .mem_a(s_a), .mem_wr(s_wr), .mem_dout(s_dout),
    .mem_din(s_din), .mem_valid(s_valid), .tx_data(s_txd), .tx_valid(s_txv), .tx_ready(1'b0),
    .rx_data(8'h00), .rx_valid(1'b0), .rx_ready(s_rxr), .halt_out(s_halt)
  );
  typedef struct {
    logic [31:0] a;
    logic wr;
    logic [7:0] d;
    logic [7:0] rxd;
    logic rxv;
    logic ev;
    logic erx;
    logic [7:0] edin;
  } vec_t;
  vec_t tv [13];
  int n_tests = 0, n_fail = 0;
  logic [7:0] m_ram [0:131071];
  logic [7:0] mq [$];
  logic [7:0] drained [$];
  logic m_halt = 1'b0;
  logic [7:0] m_din = 8'h00;
  logic [15:0] s_lf;
  logic counting = 1'b0;
  int act_st = 0, exp_st = 0;
  logic acc, rxr;
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    logic [15:0] b;
    b = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 16'h0001;
    return (x >> 1) | (b << 15);
  endfunction
  always @(posedge clk_in) s_lf <= !rst_n_in ? SEED : lfsr_next(s_lf);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] m_read(input logic [31:0] a, input logic [7:0] rxd, input logic rxv);
    if (a < IO) return m_ram[a[16:0]];
    if (a == IO) return rxd;
    if (a == IO + 32'd4) return {6'b0, rxv, mq.size() == 8};
    return 8'h00;
  endfunction
  task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d, input logic txr,
                     input logic [7:0] rxd, input logic rxv, output logic vacc, output logic vrx);
    logic ev, pop;
    logic [7:0] rv;
    mem_a = a; mem_wr = wr; mem_dout = d; tx_ready = txr; rx_data = rxd; rx_valid = rxv;
    @(negedge clk_in);
    ev = !m_halt && !(a == IO && (wr ? mq.size() == 8 : !rxv));
    chk("mem_valid", mem_valid, ev);
    chk("rx_ready", rx_ready, ev && !wr && a == IO);
    chk("tx_valid", tx_valid, mq.size() != 0);
    if (mq.size() != 0) chk("tx_data", tx_data, mq[0]);
    vacc = mem_valid;
    vrx = rx_ready;
    if (tx_valid && txr) drained.push_back(tx_data);
    pop = mq.size() != 0 && txr;
    rv = m_read(a, rxd, rxv);
    @(posedge clk_in);
    if (ev) begin
      if (!wr) m_din = rv;
      else if (a < IO) m_ram[a[16:0]] = d;
      else if (a == IO) mq.push_back(d);
      else if (a == IO + 32'd4) m_halt = 1'b1;
    end
    if (pop) void'(mq.pop_front());
    #1;
    chk("mem_din", mem_din, m_din);
    chk("halt_out", halt_out, m_halt);
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_mem_valid"}, mem_valid, 0);
    chk({tag, "_rx_ready"}, rx_ready, 0);
    chk({tag, "_mem_din"}, mem_din, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_halt_out"}, halt_out, 0);
  endtask
  task automatic mid_reset(input logic [31:0] a, input logic wr, input logic [7:0] d, input string tag);
    mem_a = a; mem_wr = wr; mem_dout = d; tx_ready = 1'b0; rx_valid = 1'b0;
    @(negedge clk_in);
    #1 rst_n_in = 1'b0;
    #1 reset_checks(tag);
    @(posedge clk_in);
    #2 rst_n_in = 1'b1;
    mq.delete();
    m_halt = 1'b0;
    m_din = 8'h00;
  endtask
  task automatic scyc(input logic [31:0] a, input logic wr, input logic [7:0] d, output logic vacc);
    s_a = a; s_wr = wr; s_dout = d;
    @(negedge clk_in);
    vacc = s_valid;
    if (counting) begin
      act_st += int'(!s_valid);
      exp_st += int'(s_lf[1:0] == 2'b00);
    end
    @(posedge clk_in);
    #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] sdat [64];
    logic [31:0] pool [8];
    logic [31:0] a;
    logic wr;
    int n;
    tv[0]  = '{32'h0001_0010 & 32'h0000_FFFF, 1'b1, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    tv[1]  = '{32'h0000_0010, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A};
    tv[2]  = '{32'h0001_FFFF, 1'b1, 8'hC3, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A};
    tv[3]  = '{32'h0001_FFFF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'hC3};
    tv[4]  = '{IO,            1'b0, 8'h00, 8'h41, 1'b0, 1'b0, 1'b0, 8'hC3};
    tv[5]  = '{IO,            1'b0, 8'h00, 8'h41, 1'b1, 1'b1, 1'b1, 8'h41};
    tv[6]  = '{IO + 32'd4,    1'b0, 8'h00, 8'h41, 1'b1, 1'b1, 1'b0, 8'h02};
    tv[7]  = '{IO + 32'd8,    1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    tv[8]  = '{IO + 32'd8,    1'b1, 8'h5F, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    tv[9]  = '{32'h0002_0010, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A};
    tv[10] = '{32'hFFFF_FFFF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    tv[11] = '{32'h0000_0000, 1'b1, 8'h77, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    tv[12] = '{32'h0000_0000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h77};
    rst_n_in = 1'b0;
    mem_a = IO; mem_wr = 1'b0; mem_dout = 8'h00; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    s_a = 32'h0; s_wr = 1'b0; s_dout = 8'h00;
    repeat (2) @(posedge clk_in);
    #1 reset_checks("reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    // stall-injecting instance: fill, then sequential refill with held addresses
    foreach (sdat[i]) sdat[i] = 8'($urandom);
    for (int i = 0; i < 64; i++) begin
      n = 0;
      do begin scyc(32'h100 + i, 1'b1, sdat[i], acc); n++; end while (!acc && n < 40);
      chk($sformatf("fill%0d_accepted", i), acc, 1);
    end
    counting = 1'b1;
    for (int i = 0; i < 64; i++) begin
      n = 0;
      do begin scyc(32'h100 + i, 1'b0, 8'h00, acc); n++; end while (!acc && n < 40);
      chk($sformatf("refill%0d_accepted", i), acc, 1);
      chk($sformatf("refill%0d_data", i), s_din, sdat[i]);
    end
    counting = 1'b0;
    chk("stall_count", act_st, exp_st);
    s_a = 32'h100; s_wr = 1'b0;
    foreach (tv[i]) begin
      cyc(tv[i].a, tv[i].wr, tv[i].d, 1'b0, tv[i].rxd, tv[i].rxv, acc, rxr);
      chk($sformatf("vec%0d_valid", i), acc, tv[i].ev);
      chk($sformatf("vec%0d_rx_ready", i), rxr, tv[i].erx);
      chk($sformatf("vec%0d_din", i), mem_din, tv[i].edin);
    end
    // TX back-pressure: eight fit, ninth waits for the first pop
    for (int i = 1; i <= 8; i++) begin
      cyc(IO, 1'b1, 8'(i), 1'b0, 8'h00, 1'b0, acc, rxr);
      chk($sformatf("bp_push%0d", i), acc, 1);
    end
    cyc(IO, 1'b1, 8'd9, 1'b0, 8'h00, 1'b0, acc, rxr);
    chk("bp_9th_blocked", acc, 0);
    drained.delete();
    cyc(IO, 1'b1, 8'd9, 1'b1, 8'h00, 1'b0, acc, rxr);
    chk("bp_9th_blocked_during_pop", acc, 0);
    cyc(IO, 1'b1, 8'd9, 1'b1, 8'h00, 1'b0, acc, rxr);
    chk("bp_9th_accepted", acc, 1);
    for (int k = 0; k < 20 && tx_valid; k++) cyc(32'h10, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, acc, rxr);
    chk("bp_drain_count", drained.size(), 9);
    for (int i = 0; i < 9 && i < drained.size(); i++) chk($sformatf("bp_drain%0d", i), drained[i], i + 1);
    // random traffic against the model
    foreach (pool[k]) begin
      pool[k] = 32'h1000 + ($urandom & 32'hFFF);
      cyc(pool[k], 1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0, acc, rxr);
    end
    for (int t = 0; t < 300; t++) begin
      int r, k;
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 7);
      a = pool[k] | ($urandom_range(0, 1) ? 32'h2_0000 : 32'h0);
      wr = r inside {[4:6]};
      if (r == 6 || r == 7) a = IO;
      else if (r == 8) a = IO + 32'd4;
      else if (r == 9) begin
        a = $urandom_range(0, 1) ? IO + 32'd8 : 32'hFFFF_FFFF;
        wr = 1'($urandom_range(0, 1));
      end
      if (r == 8) wr = 1'b0;
      cyc(a, wr, 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0, acc, rxr);
    end
    for (int k = 0; k < 20 && mq.size() != 0; k++) cyc(32'h10, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, acc, rxr);
    // halt, drain while halted, then resets in the middle of accesses
    cyc(IO, 1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, acc, rxr);
    cyc(IO, 1'b1, 8'hBB, 1'b0, 8'h00, 1'b0, acc, rxr);
    cyc(32'h1FFFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, acc, rxr);
    cyc(IO + 32'd4, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, acc, rxr);
    chk("halt_set", halt_out, 1);
    cyc(32'h10, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, acc, rxr);
    chk("halted_read_blocked", acc, 0);
    chk("halted_tx_drains", tx_data, 8'hBB);
    cyc(IO, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, acc, rxr);
    chk("halted_write_blocked", acc, 0);
    mid_reset(32'h10, 1'b1, 8'hEE, "reset_halted");
    mid_reset(32'h10, 1'b1, 8'hEE, "reset_midwrite");
    cyc(32'h10, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, acc, rxr);
    chk("ram_survives_reset", mem_din, 8'h5A);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
